// File: rtl/instr_pipeline_mem_if.sv
// Bus bundle for instr_pipeline_mem: RAM port plus producer/consumer pipeline handshakes.
// The master side drives requests and acks; the slave (the block) returns data and status.
interface instr_pipeline_mem_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_di;
   logic [DATA_W-1:0] mem_do;
   logic              in_valid;
   logic              in_ack;
   logic [DATA_W-1:0] data_in;
   logic              out_valid;
   logic              out_ack;
   logic [DATA_W-1:0] data_out;

   modport master (
      output mem_en, mem_we, mem_addr, mem_di, in_valid, data_in, out_ack,
      input  mem_do, in_ack, out_valid, data_out
   );

   modport slave (
      input  mem_en, mem_we, mem_addr, mem_di, in_valid, data_in, out_ack,
      output mem_do, in_ack, out_valid, data_out
   );
endinterface

// File: rtl/instr_pipeline_mem.sv
// Instruction pipeline subsystem: a 2**ADDR_W x DATA_W write-first RAM and an
// independent STAGES-deep valid/ack register pipeline with full-throughput backpressure.
module instr_pipeline_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int STAGES = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   instr_pipeline_mem_if.slave io_bus
);
   localparam int DEPTH = 1 << ADDR_W;

   // ---------------- RAM ----------------
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_mem_do;

   // Array has no reset so it maps onto a plain memory macro.
   always_ff @(posedge clk) begin
      if (io_bus.mem_en && io_bus.mem_we) r_mem[io_bus.mem_addr] <= io_bus.mem_di;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_mem_do <= '0;
      else if (io_bus.mem_en)  r_mem_do <= io_bus.mem_we ? io_bus.mem_di : r_mem[io_bus.mem_addr];
   end

   assign io_bus.mem_do = r_mem_do;

   // ---------------- Pipeline ----------------
   logic [STAGES-1:0]             r_vld;
   logic [STAGES-1:0][DATA_W-1:0] r_data;
   logic [STAGES-1:0]             w_adv;   // stage k hands its word downstream this edge
   logic [STAGES-1:0]             w_room;  // stage k can take a word this edge
   logic                          w_in_ok;
   logic                          w_in_ack;

   // Walk from the output stage upstream so a free slot ripples back in one cycle.
   always_comb begin
      w_adv  = '0;
      w_room = '0;
      w_adv[STAGES-1]  = r_vld[STAGES-1] & io_bus.out_ack;
      w_room[STAGES-1] = ~r_vld[STAGES-1] | w_adv[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         w_adv[k]  = r_vld[k] & w_room[k+1];
         w_room[k] = ~r_vld[k] | w_adv[k];
      end
   end

   // An X/Z in_valid falls to the default branch, so it never captures.
   always_comb begin
      w_in_ok = 1'b0;
      if (io_bus.in_valid) w_in_ok = 1'b1;
   end

   assign w_in_ack = w_in_ok & w_room[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld[0]  <= 1'b0;
         r_data[0] <= '0;
      end else if (w_in_ack) begin
         r_vld[0]  <= 1'b1;
         r_data[0] <= io_bus.data_in;
      end else if (w_adv[0]) begin
         r_vld[0]  <= 1'b0;
      end
   end

   for (genvar k = 1; k < STAGES; k++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld[k]  <= 1'b0;
            r_data[k] <= '0;
         end else if (w_adv[k-1]) begin
            r_vld[k]  <= 1'b1;
            r_data[k] <= r_data[k-1];
         end else if (w_adv[k]) begin
            r_vld[k]  <= 1'b0;
         end
      end
   end

   assign io_bus.in_ack    = w_in_ack;
   assign io_bus.out_valid = r_vld[STAGES-1];
   assign io_bus.data_out  = r_data[STAGES-1];
endmodule

// File: tb/tb_instr_pipeline_mem.sv
// Self-checking bench for instr_pipeline_mem: RAM vector table plus pipeline
// sequences scored against a queue of accepted words.
module tb_instr_pipeline_mem;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int STAGES = 3;

   logic clk;
   logic rst_n;

   instr_pipeline_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   instr_pipeline_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGES(STAGES)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] di;
      logic [DATA_W-1:0] exp_do;
   } ram_vec_t;

   ram_vec_t           tbl [12];
   logic [DATA_W-1:0]  sb [$];
   int                 n_chk  = 0;
   int                 n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Called just after a negedge with inputs driven; scores this cycle's handshakes,
   // then advances through the next rising edge to the following negedge.
   task automatic cyc(output bit acc, output bit pop);
      logic [DATA_W-1:0] e;
      acc = 1'b0;
      pop = 1'b0;
      #1;
      if (bus.in_ack === 1'b1) begin
         sb.push_back(bus.data_in);
         acc = 1'b1;
      end
      if (bus.out_valid === 1'b1 && bus.out_ack === 1'b1) begin
         pop = 1'b1;
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow: got word %0h expected none", bus.data_out);
         end else begin
            e = sb.pop_front();
            chk("sb_data", {24'd0, bus.data_out}, {24'd0, e});
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ram_run(input int lo, input int hi);
      bit a, p;
      for (int i = lo; i <= hi; i++) begin
         bus.mem_en   = tbl[i].en;
         bus.mem_we   = tbl[i].we;
         bus.mem_addr = tbl[i].addr;
         bus.mem_di   = tbl[i].di;
         cyc(a, p);
         chk($sformatf("ram_vec%0d", i), {24'd0, bus.mem_do}, {24'd0, tbl[i].exp_do});
      end
      bus.mem_en = 1'b0;
      bus.mem_we = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] items [5];
      bit   a, p;
      int   idx, pops, cycles;

      // en, we, addr, di, expected mem_do after the edge
      tbl[0]  = '{1'b1, 1'b1, 8'd0,   8'd64, 8'd64};
      tbl[1]  = '{1'b1, 1'b1, 8'd1,   8'd42, 8'd42};
      tbl[2]  = '{1'b1, 1'b0, 8'd0,   8'd0,  8'd64};
      tbl[3]  = '{1'b1, 1'b0, 8'd1,   8'd0,  8'd42};
      tbl[4]  = '{1'b0, 1'b1, 8'd0,   8'd99, 8'd42};
      tbl[5]  = '{1'b1, 1'b0, 8'd0,   8'd0,  8'd64};
      tbl[6]  = '{1'b1, 1'b1, 8'd200, 8'd7,  8'd7};
      tbl[7]  = '{1'b1, 1'b0, 8'd1,   8'd0,  8'd42};
      tbl[8]  = '{1'b1, 1'b0, 8'd200, 8'd0,  8'd7};
      tbl[9]  = '{1'b1, 1'b0, 8'd0,   8'd0,  8'd64};
      tbl[10] = '{1'b1, 1'b0, 8'd200, 8'd0,  8'd7};
      tbl[11] = '{1'b1, 1'b0, 8'd1,   8'd0,  8'd42};
      items   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};

      rst_n        = 1'b0;
      bus.mem_en   = 1'b0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_di   = '0;
      bus.in_valid = 1'b0;
      bus.data_in  = '0;
      bus.out_ack  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_mem_do",    {24'd0, bus.mem_do},    32'd0);
      chk("rst_data_out",  {24'd0, bus.data_out},  32'd0);
      rst_n = 1'b1;

      ram_run(0, 8);

      // Single word latency
      bus.in_valid = 1'b1;
      bus.data_in  = 8'd42;
      #1 chk("single_in_ack", {31'd0, bus.in_ack}, 32'd1);
      cyc(a, p);
      bus.in_valid = 1'b0;
      chk("single_not_yet", {31'd0, bus.out_valid}, 32'd0);
      for (int k = 1; k < STAGES; k++) begin
         cyc(a, p);
         chk($sformatf("single_lat%0d", k), {31'd0, bus.out_valid}, (k == STAGES - 1) ? 32'd1 : 32'd0);
      end
      chk("single_data", {24'd0, bus.data_out}, 32'd42);

      // Hold without ack, then consume once
      cyc(a, p);
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_data",  {24'd0, bus.data_out},  32'd42);
      bus.out_ack = 1'b1;
      cyc(a, p);
      chk("consume_pop", {31'd0, p}, 32'd1);
      bus.out_ack = 1'b0;
      chk("empty_after_consume", {31'd0, bus.out_valid}, 32'd0);

      // Stray ack on empty pipeline
      bus.out_ack = 1'b1;
      cyc(a, p);
      chk("stray_ack", {31'd0, bus.out_valid}, 32'd0);
      bus.out_ack = 1'b0;

      // Backpressure: only STAGES words fit
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         bus.in_valid = (idx < 5);
         bus.data_in  = items[(idx < 5) ? idx : 4];
         cyc(a, p);
         if (a) idx++;
      end
      chk("bp_accepted", idx, STAGES);
      bus.in_valid = 1'b1;
      bus.data_in  = items[idx];
      #1 chk("bp_in_ack_low", {31'd0, bus.in_ack}, 32'd0);
      chk("bp_head", {24'd0, bus.data_out}, 32'd1);

      // Drain with refill: out_valid must stay up every cycle
      bus.out_ack = 1'b1;
      pops   = 0;
      cycles = 0;
      while ((pops < 5) && (cycles < 40)) begin
         bus.in_valid = (idx < 5);
         bus.data_in  = items[(idx < 5) ? idx : 4];
         cyc(a, p);
         if (a) idx++;
         if (p) pops++;
         cycles++;
      end
      bus.in_valid = 1'b0;
      bus.out_ack  = 1'b0;
      chk("drain_pops",   pops,   32'd5);
      chk("drain_cycles", cycles, 32'd5);
      chk("drain_empty",  {31'd0, bus.out_valid}, 32'd0);
      chk("sb_empty",     sb.size(), 32'd0);

      // X on in_valid must not capture
      bus.in_valid = 1'bx;
      bus.data_in  = 8'hAA;
      #1 chk("x_in_ack", {31'd0, bus.in_ack}, 32'd0);
      for (int k = 0; k < STAGES; k++) cyc(a, p);
      chk("x_no_word", {31'd0, bus.out_valid}, 32'd0);
      bus.in_valid = 1'b0;

      // Async reset mid-stream, between clock edges
      bus.in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.data_in = 8'h10 + 8'(k);
         cyc(a, p);
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < STAGES; k++) cyc(a, p);
      chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.mem_en = 1'b1; bus.mem_addr = 8'd200; bus.mem_we = 1'b0;
      cyc(a, p);
      bus.mem_en = 1'b0;
      chk("pre_rst_mem_do", {24'd0, bus.mem_do}, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_mem_do",    {24'd0, bus.mem_do},    32'd0);
      chk("arst_data_out",  {24'd0, bus.data_out},  32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ram_run(9, 11);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/instr_pipeline_mem.md
Name: instr_pipeline_mem

Overview:
- Instruction-pipeline subsystem with two independent halves sharing one clock and reset:
  - a single-port synchronous RAM, 256 x 8;
  - a multi-stage data pipeline with valid/acknowledge handshakes on both ends.
- Sits between an instruction source/memory and the consumer (decode/controller). The consumer drains output words via a data-ready / ack protocol.

Parameters:
- DATA_W, 8, width of RAM words and pipeline data.
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W.
- STAGES, 3, number of pipeline register stages (minimum 1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all control state and output registers.
- mem_en  in  1  RAM enable; no read or write when low.
- mem_addr  in  ADDR_W  RAM address.
- mem_di  in  DATA_W  RAM write data.
- mem_we  in  1  RAM write enable (qualified by mem_en).
- mem_do  out  DATA_W  RAM registered read data.
- in_valid  in  1  data-input-ready from producer (DIR).
- in_ack  out  1  pipeline accepts data_in this cycle (ack_from_pipeline).
- data_in  in  DATA_W  producer data.
- out_valid  out  1  data-output-ready to consumer (DOR).
- out_ack  in  1  consumer acknowledge (ack_to_pipeline).
- data_out  out  DATA_W  last-stage data.

Behaviour:

RAM:
- Array is not cleared by reset; contents are undefined until written.
- Rising edge with mem_en=1, mem_we=1: mem[mem_addr] <= mem_di, and mem_do <= mem_di (write-first).
- Rising edge with mem_en=1, mem_we=0: mem_do <= mem[mem_addr]. Read latency is 1 cycle.
- mem_en=0: array and mem_do hold.
- reset low: mem_do = 0 immediately.

Pipeline:
- Each stage k holds valid[k] and data[k]. Stage 0 is the input stage; stage STAGES-1 is the output stage.
- Data passes unmodified; data_out = data[STAGES-1].
- out_valid = valid[STAGES-1].
- Output stage frees (at the edge) when out_valid && out_ack.
- Stage k advances into k+1 when valid[k] and stage k+1 is empty or freeing that same edge. This gives full throughput with backpressure propagating upstream.
- in_ack is combinational: in_ack = in_valid && (stage 0 empty or advancing this edge). When in_ack=1, data_in is captured into stage 0 at that edge.
- Latency: a word accepted at edge n is visible on out_valid/data_out after edge n+STAGES-1 (STAGES-1 cycles when downstream is empty).
- out_valid and data_out hold stable while out_ack is low; no word is ever dropped or duplicated.
- out_ack while out_valid=0 is ignored.
- Simultaneous consume and refill of the output stage on the same edge keeps out_valid=1 with the new data.
- in_valid that is X or Z is treated as 0 (no capture).
- reset low mid-operation: all valid bits clear immediately and in-flight data is discarded; data registers = 0. After release, the first edge may accept.

Test Plan:
- RAM write/read: en=1; write 64@0, then 42@1; then read @0 -> mem_do=64 one edge later; read @1 -> mem_do=42.
- RAM enable gating: en=0 with we=1, addr=0, di=99 -> mem[0] still 64 on later read; mem_do unchanged while en=0.
- Single word: after reset release, in_valid=1 with data_in=42 for one accepted cycle -> in_ack=1 that cycle; out_valid rises STAGES-1 edges later with data_out=42.
- Consumer handshake: consumer asserts registered out_ack one cycle after out_valid -> word is consumed exactly once; data_out is held until the ack edge; out_valid drops if the pipeline is empty.
- Backpressure: stream 1,2,3,4,5 with out_ack=0 -> accepts exactly STAGES words, then in_ack=0. Releasing out_ack=1 drains the words in order 1..5 with no loss or duplication.
- Async reset: assert reset low mid-stream between clock edges -> out_valid=0, mem_do=0 immediately; RAM contents are preserved.
